// File: rtl/zuc_stream_xor_pkg.sv
// Shared types for the ZUC keystream XOR block.
// Holds the word and counter widths and the control FSM encoding.
package zuc_stream_xor_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/zuc_ks_fifo.sv
// Synchronous keystream word buffer with a first-word-fall-through head.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module zuc_ks_fifo
  import zuc_stream_xor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;
  logic          do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/zuc_stream_xor.sv
// Buffers keystream words from a ZUC generator and XORs them onto a plaintext
// stream, one message of len_words 32-bit words per start request.
module zuc_stream_xor
  import zuc_stream_xor_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  len_words,
  output logic        gen_en,
  output logic [7:0]  gen_L,
  input  logic [31:0] ks_word,
  input  logic [7:0]  ks_idx,
  input  logic        ks_valid,
  input  logic [31:0] pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [31:0] ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        busy,
  output logic        done,
  output logic        err_seq,
  output logic        err_ovf
);

  state_t state;
  cnt_t   len;
  cnt_t   ks_cnt;
  cnt_t   out_cnt;
  word_t  fifo_head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_clr;
  logic   ks_push;
  logic   pt_fire;
  logic   ct_fire;

  assign ks_push  = gen_en && ks_valid;
  assign pt_ready = (state == ST_RUN) && !fifo_empty && (out_cnt < len) &&
                    (!ct_valid || ct_ready);
  assign pt_fire  = pt_valid && pt_ready;
  assign ct_fire  = ct_valid && ct_ready;
  assign busy     = (state != ST_IDLE);
  // Leftover keystream is flushed both when a new message starts and when one ends.
  assign fifo_clr = ((state == ST_IDLE) && start && (len_words != 8'd0)) || (state == ST_FIN);

  zuc_ks_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (ks_push),
    .pop   (pt_fire),
    .din   (ks_word),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      ks_cnt   <= '0;
      out_cnt  <= '0;
      gen_en   <= 1'b0;
      gen_L    <= '0;
      ct_data  <= '0;
      ct_valid <= 1'b0;
      done     <= 1'b0;
      err_seq  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len_words != 8'd0) begin
              len     <= len_words;
              gen_L   <= len_words;
              ks_cnt  <= '0;
              out_cnt <= '0;
              err_seq <= 1'b0;
              err_ovf <= 1'b0;
              gen_en  <= 1'b1;
              state   <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Every strobe counts, even a dropped one, so the generator stops on time.
          if (ks_push) begin
            ks_cnt <= cnt_t'(ks_cnt + 1'b1);
            if (ks_idx != ks_cnt)       err_seq <= 1'b1;
            if (fifo_full && !pt_fire)  err_ovf <= 1'b1;
            if (cnt_t'(ks_cnt + 1'b1) == len) gen_en <= 1'b0;
          end
          if (pt_fire) begin
            ct_data  <= pt_data ^ fifo_head;
            ct_valid <= 1'b1;
            out_cnt  <= cnt_t'(out_cnt + 1'b1);
          end else if (ct_fire) begin
            ct_valid <= 1'b0;
          end
          if (ct_fire && (out_cnt == len)) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          gen_en <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zuc_stream_xor.sv
// Directed bench for zuc_stream_xor: ciphertext is predicted as pt[i] ^ ks[i]
// in message order and checked on every accepted ct word.
module tb_zuc_stream_xor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len_words;
  logic        gen_en;
  logic [7:0]  gen_L;
  logic [31:0] ks_word;
  logic [7:0]  ks_idx;
  logic        ks_valid;
  logic [31:0] pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [31:0] ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic        busy;
  logic        done;
  logic        err_seq;
  logic        err_ovf;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data = '0;

  zuc_stream_xor #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .gen_en(gen_en), .gen_L(gen_L), .ks_word(ks_word), .ks_idx(ks_idx),
    .ks_valid(ks_valid), .pt_data(pt_data), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .ct_data(ct_data), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .busy(busy), .done(done), .err_seq(err_seq),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output monitor: ciphertext order/value, hold stability and backpressure on pt_ready.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (ct_valid) begin
        if (hold_prev) check("ct_hold_stable", ct_data, prev_data);
        if (!ct_ready) check("pt_ready_backpressure", {31'd0, pt_ready}, 32'd0);
        if (ct_ready) begin
          if (exp_q.size() == 0) check("ct_unexpected", 32'd1, 32'd0);
          else check("ct_data", ct_data, exp_q.pop_front());
        end
        hold_prev = !ct_ready;
        prev_data = ct_data;
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] len);
    start = 1'b1;
    len_words = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_ks(input logic [31:0] w, input logic [7:0] idx);
    ks_valid = 1'b1;
    ks_word = w;
    ks_idx = idx;
    @(posedge clk); #1;
    ks_valid = 1'b0;
  endtask

  task automatic wait_hs();
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pt_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("pt_handshake_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    pt_valid = 1'b0;
  endtask

  task automatic send_pt(input logic [31:0] pt, input logic [31:0] exp);
    exp_q.push_back(exp);
    pt_valid = 1'b1;
    pt_data = pt;
    wait_hs();
  endtask

  task automatic checkOutput(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt, seen ? 32'd1 : 32'd1 + 32'd100);
    check({name, "_exp_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    done_cnt = 0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_gen_en"},   {31'd0, gen_en},   32'd0);
    check({name, "_gen_L"},    {24'd0, gen_L},    32'd0);
    check({name, "_pt_ready"}, {31'd0, pt_ready}, 32'd0);
    check({name, "_ct_valid"}, {31'd0, ct_valid}, 32'd0);
    check({name, "_ct_data"},  ct_data,           32'd0);
    check({name, "_busy"},     {31'd0, busy},     32'd0);
    check({name, "_done"},     {31'd0, done},     32'd0);
    check({name, "_err_seq"},  {31'd0, err_seq},  32'd0);
    check({name, "_err_ovf"},  {31'd0, err_ovf},  32'd0);
  endtask

  initial begin
    logic [31:0] ks;
    logic [31:0] pt;
    rst = 1'b1; start = 1'b0; len_words = '0; ks_word = '0; ks_idx = '0;
    ks_valid = 1'b0; pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_values("por");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic two-word message");
    applyStimulus(8'd2);
    check("basic_gen_en", {31'd0, gen_en}, 32'd1);
    check("basic_gen_L", {24'd0, gen_L}, 32'd2);
    check("basic_busy", {31'd0, busy}, 32'd1);
    send_ks(32'h14f1c272, 8'd0);
    send_ks(32'h3279c419, 8'd1);
    check("basic_gen_en_off", {31'd0, gen_en}, 32'd0);
    send_pt(32'h00000000, 32'h14f1c272);
    send_pt(32'hffffffff, 32'hcd863be6);
    checkOutput("basic");
    check("basic_err_seq", {31'd0, err_seq}, 32'd0);
    check("basic_err_ovf", {31'd0, err_ovf}, 32'd0);

    $display("[TB] ct backpressure");
    applyStimulus(8'd3);
    send_ks(32'h01234567, 8'd0);
    send_ks(32'h89abcdef, 8'd1);
    send_ks(32'h0f0f0f0f, 8'd2);
    ct_ready = 1'b0;
    send_pt(32'hdeadbeef, 32'hdeadbeef ^ 32'h01234567);
    exp_q.push_back(32'h12345678 ^ 32'h89abcdef);
    pt_valid = 1'b1;
    pt_data = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_pt_ready", {31'd0, pt_ready}, 32'd0);
      check("stall_ct_valid", {31'd0, ct_valid}, 32'd1);
    end
    @(posedge clk); #1;
    ct_ready = 1'b1;
    wait_hs();
    send_pt(32'ha5a5a5a5, 32'ha5a5a5a5 ^ 32'h0f0f0f0f);
    checkOutput("stall");

    $display("[TB] keystream overflow");
    applyStimulus(8'd6);
    for (int i = 0; i < 6; i++) begin
      send_ks(32'h1000_0000 + i, 8'(i));
      if (i == 3) check("ovf_before_5th", {31'd0, err_ovf}, 32'd0);
      if (i == 4) check("ovf_after_5th", {31'd0, err_ovf}, 32'd1);
    end
    check("ovf_gen_en_off", {31'd0, gen_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pt = 32'h5555_0000 + i;
      send_pt(pt, pt ^ (32'h1000_0000 + i));
    end
    repeat (2) @(negedge clk);
    check("ovf_fifo_drained", {31'd0, pt_ready}, 32'd0);
    check("ovf_sticky", {31'd0, err_ovf}, 32'd1);
    do_reset();

    $display("[TB] index sequence error");
    applyStimulus(8'd2);
    send_ks(32'hcafef00d, 8'd0);
    check("seq_ok_first", {31'd0, err_seq}, 32'd0);
    send_ks(32'h0badc0de, 8'd2);
    check("seq_err_set", {31'd0, err_seq}, 32'd1);
    send_pt(32'h11111111, 32'h11111111 ^ 32'hcafef00d);
    send_pt(32'h22222222, 32'h22222222 ^ 32'h0badc0de);
    checkOutput("seq");
    check("seq_err_sticky", {31'd0, err_seq}, 32'd1);

    $display("[TB] zero length and start during run");
    start = 1'b1;
    len_words = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_gen_en", {31'd0, gen_en}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    check("zero_gen_en_after", {31'd0, gen_en}, 32'd0);
    done_cnt = 0;
    applyStimulus(8'd2);
    check("run_err_cleared", {31'd0, err_seq}, 32'd0);
    applyStimulus(8'd5);
    check("run_start_ignored", {24'd0, gen_L}, 32'd2);
    send_ks(32'h00ff00ff, 8'd0);
    send_ks(32'hff00ff00, 8'd1);
    send_pt(32'h0f0f0f0f, 32'h0f0f0f0f ^ 32'h00ff00ff);
    send_pt(32'hf0f0f0f0, 32'hf0f0f0f0 ^ 32'hff00ff00);
    checkOutput("ignore");

    $display("[TB] reset mid-message");
    applyStimulus(8'd3);
    send_ks(32'h76543210, 8'd0);
    ct_ready = 1'b0;
    send_pt(32'h0, 32'h76543210);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    exp_q.delete();
    rst = 1'b0;
    ct_ready = 1'b1;
    done_cnt = 0;
    applyStimulus(8'd1);
    send_ks(32'hfeedface, 8'd0);
    send_pt(32'h13572468, 32'h13572468 ^ 32'hfeedface);
    checkOutput("after_rst");

    $display("[TB] maximum length message");
    applyStimulus(8'd255);
    for (int i = 0; i < 255; i++) begin
      ks = 32'h9e3779b9 * (i + 1);
      pt = {24'h0, 8'(i)} ^ 32'ha0a0a0a0;
      send_ks(ks, 8'(i));
      send_pt(pt, pt ^ ks);
    end
    checkOutput("len255");
    check("len255_err_seq", {31'd0, err_seq}, 32'd0);
    check("len255_err_ovf", {31'd0, err_ovf}, 32'd0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
